// File: rtl/video_ram.sv
// Shared CPU / screen RAM with a hardware fill engine.
// Screen reads are never stalled; the CPU port is stalled while the fill engine writes.
module video_ram #(
    parameter int unsigned WIDTH             = 8,
    parameter int unsigned REGISTER_COUNT    = 256,
    parameter int unsigned RAM_SCREEN_OFFSET = 128,
    parameter int unsigned SCREEN_COUNT      = 128,
    parameter int unsigned LANES             = 1,
    localparam int unsigned AW = $clog2(REGISTER_COUNT),
    localparam int unsigned SW = $clog2(SCREEN_COUNT)
) (
    input  logic              cpu_clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     addr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              we,
    input  logic [LANES-1:0]  be,
    output logic [WIDTH-1:0]  rdata,
    output logic              cpu_ready,
    input  logic [SW-1:0]     addr_screen,
    input  logic              screen_re,
    output logic [WIDTH-1:0]  rdata_screen,
    output logic              rdata_screen_valid,
    input  logic              fill_start,
    input  logic [AW-1:0]     fill_base,
    input  logic [AW:0]       fill_len,
    input  logic [WIDTH-1:0]  fill_value,
    output logic              fill_busy,
    output logic              fill_done
);

    localparam int unsigned LW = WIDTH / LANES;

    if (RAM_SCREEN_OFFSET + SCREEN_COUNT > REGISTER_COUNT) begin : g_bad_window
        $error("video_ram: screen window exceeds storage");
    end
    if (WIDTH % LANES != 0) begin : g_bad_lanes
        $error("video_ram: WIDTH must be a multiple of LANES");
    end

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q;
    logic [AW:0]      cnt_q;
    logic [WIDTH-1:0] val_q;
    logic             ready_d, busy_d, done_d;

    logic [WIDTH-1:0] mem [REGISTER_COUNT];

    logic             cpu_in_range, scr_in_range, start_ok, start_zero;
    logic [AW-1:0]    scr_idx;
    logic [WIDTH-1:0] lane_mask;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    assign cpu_in_range = ({1'b0, addr} < (AW+1)'(REGISTER_COUNT));
    assign scr_in_range = ({1'b0, addr_screen} < (SW+1)'(SCREEN_COUNT));
    assign scr_idx      = AW'(RAM_SCREEN_OFFSET) + AW'(addr_screen);
    assign start_ok     = (state_q == IDLE) && fill_start && (fill_len != '0);
    assign start_zero   = (state_q == IDLE) && fill_start && (fill_len == '0);

    // State register plus registered FSM outputs and fill datapath
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            val_q     <= '0;
            cpu_ready <= 1'b1;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpu_ready <= ready_d;
            fill_busy <= busy_d;
            fill_done <= done_d;
            if (start_ok) begin
                ptr_q <= fill_base;
                cnt_q <= fill_len;
                val_q <= fill_value;
            end else if (state_q == FILL) begin
                ptr_q <= (ptr_q == AW'(REGISTER_COUNT - 1)) ? '0 : ptr_q + AW'(1);
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = FILL;
            FILL:    if (cnt_q == (AW+1)'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they line up with it after the edge
    always_comb begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (state_d == FILL) ready_d = 1'b0;
        if (state_d != IDLE) busy_d  = 1'b1;
        if ((state_d == DONE) || start_zero) done_d = 1'b1;
    end

    // Single write port: fill has priority, CPU merges enabled lanes into the old word
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i*LW +: LW] = {LW{be[i]}};
        end
        wr_en   = 1'b0;
        wr_addr = addr;
        wr_data = (mem[addr] & ~lane_mask) | (wdata & lane_mask);
        if (state_q == FILL) begin
            wr_en   = ({1'b0, ptr_q} < (AW+1)'(REGISTER_COUNT));
            wr_addr = ptr_q;
            wr_data = val_q;
        end else if (cpu_ready && we && cpu_in_range) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read ports; non-blocking update gives read-first behaviour
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata              <= '0;
            rdata_screen       <= '0;
            rdata_screen_valid <= 1'b0;
        end else begin
            if (cpu_ready) rdata <= cpu_in_range ? mem[addr] : '0;
            if (screen_re) rdata_screen <= scr_in_range ? mem[scr_idx] : '0;
            rdata_screen_valid <= screen_re;
        end
    end

endmodule

// File: doc/video_ram.md
# video_ram

Single-clock, parametrised successor to the CPU/screen RAM. It holds the CPU data memory and the frame buffer window, and has three users:
- a CPU port with byte-lane write enables and a registered read;
- a screen port with a read strobe and a valid flag, never stalled;
- a hardware fill engine that writes one word per cycle over a region while stalling the CPU.

It sits between the CPU datapath and the VGA scan logic. The VGA logic reads the window `[RAM_SCREEN_OFFSET, RAM_SCREEN_OFFSET+SCREEN_COUNT)`.

## Interface
- WIDTH, 8, data word width; must be a multiple of LANES
- REGISTER_COUNT, 256, words of storage
- RAM_SCREEN_OFFSET, 128, first word of the screen window
- SCREEN_COUNT, 128, words in the screen window; RAM_SCREEN_OFFSET+SCREEN_COUNT ≤ REGISTER_COUNT (elaboration error otherwise)
- LANES, 1, byte/lane write-enable count; lane width = WIDTH/LANES
- cpu_clk  in  1  sole clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- addr  in  AW=$clog2(REGISTER_COUNT)  CPU word address
- wdata  in  WIDTH  CPU write data
- we  in  1  CPU write enable
- be  in  LANES  per-lane write enable, qualified by we
- rdata  out  WIDTH  CPU read data, registered
- cpu_ready  out  1  high when CPU access is accepted
- addr_screen  in  $clog2(SCREEN_COUNT)  offset inside the screen window
- screen_re  in  1  screen read strobe
- rdata_screen  out  WIDTH  screen read data, registered
- rdata_screen_valid  out  1  rdata_screen updated this cycle
- fill_start  in  1  start-fill pulse
- fill_base  in  AW  first fill address
- fill_len  in  AW+1  words to fill, 0..REGISTER_COUNT
- fill_value  in  WIDTH  fill word
- fill_busy  out  1  fill engine active
- fill_done  out  1  one-cycle completion pulse

## Operation
- **Reset values** (rst_n low): rdata=0, rdata_screen=0, rdata_screen_valid=0, fill_busy=0, fill_done=0, cpu_ready=1, FSM=IDLE. Memory contents are not reset.
- **CPU port**, active when cpu_ready=1:
  - Write: when we=1, lanes with be[i]=1 are written; other lanes are kept.
  - Read: rdata <= memory[addr] every accepted cycle, read-first (a same-address write returns the old word).
  - Out of range (addr ≥ REGISTER_COUNT): writes are dropped and rdata <= 0.
  - When cpu_ready=0: we is ignored and rdata holds its value.
- **Screen port:**
  - When screen_re=1: index = RAM_SCREEN_OFFSET+addr_screen; rdata_screen <= memory[index] (0 if addr_screen ≥ SCREEN_COUNT); rdata_screen_valid <= 1.
  - When screen_re=0: rdata_screen holds and valid <= 0.
  - Read-first against CPU writes and fill writes in the same cycle.
  - Never stalled, including during a fill.
- **Fill FSM** (IDLE, FILL, DONE):
  - IDLE: fill_start=1 with fill_len≠0 latches base, len and value, then goes to FILL.
  - IDLE: fill_start=1 with fill_len=0 pulses fill_done the next cycle and stays in IDLE; no writes occur.
  - FILL: each cycle writes fill_value to memory[ptr] on all lanes; ptr increments, wrapping from REGISTER_COUNT-1 to 0; count decrements. The cycle that writes the last word (count=1) goes to DONE.
  - DONE: fill_done=1 for one cycle, then IDLE.
  - fill_start while not in IDLE is ignored.
  - fill_busy=1 in FILL and DONE.
  - cpu_ready=0 only in FILL.
- **Reset mid-fill:** the FSM returns to IDLE immediately. Words already written stay written; fill_done is not pulsed.

## Timing
- CPU read latency 1: address at edge N gives rdata valid after edge N+1.
- Screen read latency 1: screen_re at edge N gives rdata_screen and rdata_screen_valid after edge N+1.
- Fill of L words, fill_start sampled at edge N:
  - FILL occupies edges N+1..N+L, writing one word per edge;
  - DONE is held through cycle N+L+1, with the fill_done pulse there;
  - cpu_ready is low for exactly L cycles.
- The CPU must hold addr/wdata/we while cpu_ready=0; the block does not queue requests.
- Write-to-read: a word written at edge N is visible to a read sampled at edge N+1.

## Test plan
- **Reset:** assert rst_n=0 mid-traffic → all outputs at reset values asynchronously; cpu_ready=1.
- **Byte lanes** (LANES=2, WIDTH=16):
  - stimulus: write 0xABCD at addr 5 with be=11, then 0x1200 with be=10; read addr 5;
  - response: rdata=0x12CD one cycle after the read.
- **Read-first:**
  - stimulus: same cycle CPU writes 0x55 to addr 130 and screen_re with addr_screen=2 (old content 0x11);
  - response: rdata_screen=0x11 and valid=1; the next screen read returns 0x55.
- **Fill with wrap** (REGISTER_COUNT=256):
  - stimulus: fill_base=254, fill_len=4, fill_value=0x7E;
  - response: addresses 254, 255, 0 and 1 become 0x7E; address 2 is unchanged; cpu_ready low 4 cycles; fill_done one pulse at cycle 5.
- **Fill edge cases:**
  - fill_len=0 → fill_done next cycle, fill_busy never high, memory unchanged;
  - second fill_start during FILL → ignored.
- **Reset mid-fill:**
  - stimulus: fill_len=10, rst_n low after 3 writes;
  - response: exactly 3 words written, no fill_done, cpu_ready=1.
